// File: rtl/mod_exp_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mod_exp_ctrl_if
//  Description : Handshake bundle between the command side, the modular
//                exponentiation sequencer and the Montgomery multiplier with
//                its operand muxes.
//                  start, exponent  : command request into the sequencer
//                  mmm_done         : multiplier result-valid pulse
//                  mmm_start        : multiplier launch pulse
//                  op_a_sel/op_b_sel/op_b_reg_sel : operand mux selects
//                  p_we, z_we       : result register write enables
//                  busy, done       : command status
//                master = sequencer side, slave = environment side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mod_exp_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] exponent;
    logic             mmm_done;
    logic             mmm_start;
    logic [1:0]       op_a_sel;
    logic [1:0]       op_b_sel;
    logic             op_b_reg_sel;
    logic             p_we;
    logic             z_we;
    logic             busy;
    logic             done;

    modport master (
        input  start, exponent, mmm_done,
        output mmm_start, op_a_sel, op_b_sel, op_b_reg_sel, p_we, z_we, busy, done
    );

    modport slave (
        output start, exponent, mmm_done,
        input  mmm_start, op_a_sel, op_b_sel, op_b_reg_sel, p_we, z_we, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/mod_exp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mod_exp_ctrl
//  Description : Left-to-right square-and-multiply sequencer for the
//                Montgomery multiplier of the RSA core. Converts the message
//                and 1 into the Montgomery domain, walks the exponent from
//                the MSB down (square always, multiply on a set bit), then
//                converts the result back out of the Montgomery domain.
//  Ports       : clk   - system clock, rising edge
//                rst_n - synchronous active-low reset
//                bus   - mod_exp_ctrl_if.master (start/exponent in,
//                        multiplier strobes, mux selects, P/Z write
//                        enables, busy/done out)
//  Parameters  : WIDTH - exponent width in bits
//  Macro       : MODEXP_LZ_SKIP_EN - when defined, leading zero bits of the
//                exponent are skipped one cycle each instead of squaring.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_exp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    mod_exp_ctrl_if.master  bus
);
    localparam int            CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

    localparam logic [1:0] A_P   = 2'b00;
    localparam logic [1:0] A_MSG = 2'b01;
    localparam logic [1:0] A_ONE = 2'b10;
    localparam logic [1:0] B_REG = 2'b00;
    localparam logic [1:0] B_R2  = 2'b01;
    localparam logic [1:0] B_ONE = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_CONV_X = 4'd1,
        S_CONV_1 = 4'd2,
        S_SQR    = 4'd3,
        S_MUL    = 4'd4,
        S_NEXT   = 4'd5,
        S_SKIP   = 4'd6,
        S_POST   = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    state_t           state_q, state_d;
    logic             wait_q, wait_d;          // 0 = ISSUE phase, 1 = WAIT phase
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mmm_start_q, mmm_start_d;
    logic [1:0]       op_a_sel_q, op_a_sel_d;
    logic [1:0]       op_b_sel_q, op_b_sel_d;
    logic             op_b_reg_sel_q, op_b_reg_sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             op_done;                 // multiplier finished the current op
    logic             enter_op;                // next cycle is the ISSUE of a new op
    logic [CW-1:0]    cnt_m1;
    logic             bit_cur;

    function automatic logic is_op(input state_t s);
        return (s == S_CONV_X) || (s == S_CONV_1) || (s == S_SQR) ||
               (s == S_MUL)    || (s == S_POST);
    endfunction

    always_comb begin
        cnt_m1   = cnt_q - CW'(1);
        bit_cur  = exp_q[cnt_q];
        // A done pulse only counts in WAIT; during ISSUE or outside an op it is dropped.
        op_done  = wait_q && bus.mmm_done;
        state_d  = state_q;
        exp_d    = exp_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    exp_d   = bus.exponent;
                    cnt_d   = CNT_TOP;
                    state_d = S_CONV_X;
                end
            end
            S_CONV_X: if (op_done) state_d = S_CONV_1;
            S_CONV_1: begin
                if (op_done) begin
`ifdef MODEXP_LZ_SKIP_EN
                    state_d = bit_cur ? S_SQR : S_SKIP;
`else
                    state_d = S_SQR;
`endif
                end
            end
            S_SQR:  if (op_done) state_d = bit_cur ? S_MUL : S_NEXT;
            S_MUL:  if (op_done) state_d = S_NEXT;
            S_NEXT: begin
                if (cnt_q == '0) begin
                    state_d = S_POST;
                end else begin
                    cnt_d   = cnt_m1;
                    state_d = S_SQR;
                end
            end
            S_SKIP: begin
`ifdef MODEXP_LZ_SKIP_EN
                // Squaring the Montgomery 1 leaves it unchanged, so leading
                // zeros cost one idle cycle each until the top set bit.
                if (cnt_q == '0) begin
                    state_d = S_POST;
                end else begin
                    cnt_d   = cnt_m1;
                    state_d = exp_q[cnt_m1] ? S_SQR : S_SKIP;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_POST: if (op_done) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // No op follows itself directly, so a state change into an op marks ISSUE.
        enter_op    = is_op(state_d) && (state_d != state_q);
        wait_d      = is_op(state_d) && !enter_op;
        mmm_start_d = enter_op;
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);

        // Selects follow the next state so they are valid with mmm_start and
        // stay put through the whole WAIT phase.
        op_a_sel_d     = A_P;
        op_b_sel_d     = B_REG;
        op_b_reg_sel_d = 1'b0;
        case (state_d)
            S_CONV_X: begin op_a_sel_d = A_MSG; op_b_sel_d = B_R2;  end
            S_CONV_1: begin op_a_sel_d = A_ONE; op_b_sel_d = B_R2;  end
            S_SQR:    begin op_a_sel_d = A_P;   op_b_sel_d = B_REG; end
            S_MUL:    begin op_a_sel_d = A_P;   op_b_sel_d = B_REG; op_b_reg_sel_d = 1'b1; end
            S_POST:   begin op_a_sel_d = A_P;   op_b_sel_d = B_ONE; end
            default:  begin op_a_sel_d = A_P;   op_b_sel_d = B_REG; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            wait_q         <= 1'b0;
            exp_q          <= '0;
            cnt_q          <= '0;
            mmm_start_q    <= 1'b0;
            op_a_sel_q     <= 2'b00;
            op_b_sel_q     <= 2'b00;
            op_b_reg_sel_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_q         <= wait_d;
            exp_q          <= exp_d;
            cnt_q          <= cnt_d;
            mmm_start_q    <= mmm_start_d;
            op_a_sel_q     <= op_a_sel_d;
            op_b_sel_q     <= op_b_sel_d;
            op_b_reg_sel_q <= op_b_reg_sel_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    // Write enables must coincide with the mmm_done cycle, so they are decoded
    // combinationally; rst_n gates them so a reset cycle never writes.
    assign bus.p_we = rst_n && op_done &&
                      ((state_q == S_CONV_1) || (state_q == S_SQR) ||
                       (state_q == S_MUL)    || (state_q == S_POST));
    assign bus.z_we = rst_n && op_done && (state_q == S_CONV_X);

    assign bus.mmm_start    = mmm_start_q;
    assign bus.op_a_sel     = op_a_sel_q;
    assign bus.op_b_sel     = op_b_sel_q;
    assign bus.op_b_reg_sel = op_b_reg_sel_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule
`default_nettype wire

// File: tb/tb_mod_exp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_exp_ctrl
//  Description : Scoreboard bench for mod_exp_ctrl. A small datapath model
//                (P/Z registers, operand muxes, Montgomery multiplier with a
//                fixed latency, modulus 97, R = 2^8) follows the DUT selects;
//                expected op sequences and x^e mod N are queued at start.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_exp_ctrl;
    localparam int W   = 8;
    localparam int N   = 97;
    localparam int RM  = 256 % N;
    localparam int R2  = (RM * RM) % N;
    localparam int LAT = 4;
`ifdef MODEXP_LZ_SKIP_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    typedef struct packed {
        logic [4:0] code;   // {a_sel, b_sel, b_reg_sel (only when b_sel==00)}
        logic       to_z;
    } op_t;

    typedef struct {
        int res;
        int starts;
    } run_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mod_exp_ctrl_if #(.WIDTH(W)) bus ();
    mod_exp_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    op_t  opq[$];
    run_t resq[$];

    int   n_vec = 0;
    int   n_err = 0;
    int   rinv, cd, pend_res, pm, zm, msg;
    int   run_starts, run_pwe, run_zwe, sqr_seen;
    bit   gen_pend, genuine, pend_z, saw_done;
    bit   start_drv, rst_drv, stray_done, stray_issue;
    logic [W-1:0] exp_drv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic int mont(input int a, input int b);
        return (((a * b) % N) * rinv) % N;
    endfunction

    function automatic int opnd_a(input logic [1:0] s);
        case (s)
            2'b00:   return pm;
            2'b01:   return msg;
            2'b10:   return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int opnd_b(input logic [1:0] s, input logic breg);
        case (s)
            2'b00:   return breg ? zm : pm;
            2'b01:   return R2;
            2'b10:   return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int ref_pow(input int m, input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = (r * m) % N;
        return r;
    endfunction

    function automatic logic [31:0] outvec();
        return {22'd0, bus.mmm_start, bus.op_a_sel, bus.op_b_sel, bus.op_b_reg_sel,
                bus.p_we, bus.z_we, bus.busy, bus.done};
    endfunction

    // One clock: drive inputs just after the edge, observe on the falling edge.
    task automatic tick();
        bit         done_now;
        logic [4:0] code;
        op_t        o;
        run_t       r;
        @(posedge clk);
        #1;
        rst_n        = rst_drv;
        bus.start    = start_drv;
        bus.exponent = exp_drv;
        done_now     = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) done_now = 1'b1;
        end
        genuine      = done_now & gen_pend;
        bus.mmm_done = done_now | stray_done | (stray_issue & bus.mmm_start);
        @(negedge clk);

        chk("excl", 32'($countones({bus.p_we, bus.z_we, bus.mmm_start, bus.done}) <= 1), 32'd1);
        chk("we", {30'd0, bus.p_we, bus.z_we}, {30'd0, genuine & ~pend_z, genuine & pend_z});
        if (bus.p_we) begin pm = pend_res; run_pwe++; end
        if (bus.z_we) begin zm = pend_res; run_zwe++; end
        if (genuine) gen_pend = 1'b0;
        if (!rst_drv) begin
            gen_pend = 1'b0;
            opq.delete();
            resq.delete();
        end

        if (bus.mmm_start) begin
            pend_res = mont(opnd_a(bus.op_a_sel), opnd_b(bus.op_b_sel, bus.op_b_reg_sel));
            cd       = LAT;
            gen_pend = 1'b1;
            run_starts++;
            code = {bus.op_a_sel, bus.op_b_sel, (bus.op_b_sel == 2'b00) ? bus.op_b_reg_sel : 1'b0};
            if (code == 5'b00000) sqr_seen++;
            chk("op_avail", 32'(opq.size() > 0), 32'd1);
            if (opq.size() > 0) begin
                o      = opq.pop_front();
                pend_z = o.to_z;
                chk("op_code", {27'd0, code}, {27'd0, o.code});
            end
        end

        if (bus.done) begin
            saw_done = 1'b1;
            chk("busy_at_done", {31'd0, bus.busy}, 32'd1);
            chk("done_avail", 32'(resq.size() > 0), 32'd1);
            if (resq.size() > 0) begin
                r = resq.pop_front();
                chk("result",   32'(pm),         32'(r.res));
                chk("starts",   32'(run_starts), 32'(r.starts));
                chk("p_we_cnt", 32'(run_pwe),    32'(r.starts - 1));
                chk("z_we_cnt", 32'(run_zwe),    32'd1);
                chk("ops_left", 32'(opq.size()), 32'd0);
            end
        end
    endtask

    task automatic run(input logic [W-1:0] e, input int m, input bit busy_poke, input bit with_rst);
        int msb, pc, nst;
        bit fin;
        msg = m;
        msb = -1;
        pc  = 0;
        for (int i = 0; i < W; i++) if (e[i]) begin msb = i; pc++; end
        if (LZ) nst = (e == 0) ? 3 : 2 + (msb + 1) + pc + 1;
        else    nst = 2 + W + pc + 1;

        opq.push_back('{code: 5'b01010, to_z: 1'b1});   // CONV_X
        opq.push_back('{code: 5'b10010, to_z: 1'b0});   // CONV_1
        for (int i = W - 1; i >= 0; i--) begin
            if (!(LZ && i > msb)) begin
                opq.push_back('{code: 5'b00000, to_z: 1'b0});             // SQR
                if (e[i]) opq.push_back('{code: 5'b00001, to_z: 1'b0});   // MUL
            end
        end
        opq.push_back('{code: 5'b00100, to_z: 1'b0});   // POST
        resq.push_back('{res: ref_pow(m, int'(e)), starts: nst});

        run_starts = 0; run_pwe = 0; run_zwe = 0; sqr_seen = 0; saw_done = 1'b0;
        start_drv = 1'b1;
        exp_drv   = e;
        tick();
        start_drv = 1'b0;
        exp_drv   = ~e;
        chk("busy_pre", {31'd0, bus.busy}, 32'd0);
        tick();
        chk("busy_rise", {31'd0, bus.busy}, 32'd1);

        fin = 1'b0;
        for (int k = 0; k < 2000 && !saw_done && !fin; k++) begin
            if (busy_poke && k == 10) begin
                start_drv = 1'b1;
                exp_drv   = {W{1'b1}};
            end else begin
                start_drv = 1'b0;
            end
            if (with_rst && sqr_seen == 3 && cd == 2) begin
                rst_drv = 1'b0;
                tick();
                rst_drv = 1'b1;
                tick();   // the abandoned op's mmm_done lands here
                chk("rst_idle", outvec(), 32'd0);
                fin = 1'b1;
            end else begin
                tick();
            end
        end
        start_drv = 1'b0;
        if (!fin) begin
            chk("timeout", {31'd0, saw_done}, 32'd1);
            tick();
            chk("idle_after_done", {30'd0, bus.busy, bus.done}, 32'd0);
        end
        repeat (6) tick();
    endtask

    initial begin
        rinv = 0;
        for (int r = 1; r < N; r++) if ((RM * r) % N == 1) rinv = r;
        rst_drv = 1'b0; start_drv = 1'b0; exp_drv = '0;
        stray_done = 1'b0; stray_issue = 1'b0;
        cd = 0; gen_pend = 1'b0; pend_z = 1'b0; pend_res = 0;
        pm = 0; zm = 0; msg = 0; saw_done = 1'b0; sqr_seen = 0;
        run_starts = 0; run_pwe = 0; run_zwe = 0;
        rst_n = 1'b0; bus.start = 1'b0; bus.exponent = '0; bus.mmm_done = 1'b0;

        repeat (3) tick();
        chk("reset", outvec(), 32'd0);
        rst_drv = 1'b1;

        // Idle with stray done pulses: nothing may move.
        for (int i = 0; i < 20; i++) begin
            stray_done = (i % 3 == 1);
            tick();
            chk("idle", outvec(), 32'd0);
        end
        stray_done = 1'b0;
        tick();

        run(8'h05, 7,  1'b0, 1'b0);
        run(8'h00, 23, 1'b0, 1'b0);
        run(8'hFF, 45, 1'b0, 1'b0);
        run(8'h80, 3,  1'b0, 1'b0);
        run(8'h01, 88, 1'b0, 1'b0);
        run(8'h0B, 12, 1'b1, 1'b0);   // start pulsed mid-run
        stray_issue = 1'b1;
        run(8'hA6, 50, 1'b0, 1'b0);   // stray mmm_done on every ISSUE cycle
        stray_issue = 1'b0;
        run(8'h05, 7,  1'b0, 1'b1);   // reset during third SQR wait
        run(8'hA3, 61, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mod_exp_ctrl.md
Name: mod_exp_ctrl

Overview:
- Sequencer for the Montgomery-multiplier datapath of the RSA core. Performs left-to-right square-and-multiply modular exponentiation.
- Drives the two operand-mux selects, the multiplier start strobe and the P/Z result-register write enables.
- Waits on the multiplier's done strobe between operations.
- Sits between the top-level command interface (start/exponent) and the multiplier plus its operand muxes.

Parameters:
WIDTH, 8, exponent width in bits; bit counter is $clog2(WIDTH) bits.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  begin exponentiation; sampled only in IDLE
exponent  input  WIDTH  exponent e; latched on accepted start
mmm_done  input  1  one-cycle pulse from multiplier: result valid
mmm_start  output  1  one-cycle pulse: multiplier begins an operation
op_a_sel  output  2  operand-A mux select: 00=P reg, 01=message, 10=one, 11=zero
op_b_sel  output  2  operand-B mux select: 00=P/Z reg (per op_b_reg_sel), 01=R2 constant, 10=one, 11=zero
op_b_reg_sel  output  1  0=P reg, 1=Z reg onto operand-B mux input 00
p_we  output  1  write multiplier result into P (one cycle)
z_we  output  1  write multiplier result into Z (one cycle)
busy  output  1  operation in progress
done  output  1  one-cycle pulse: P holds x^e mod N

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; all outputs 0; latched exponent and bit counter cleared. Applies mid-operation; the operation is abandoned and no p_we/z_we is issued afterwards.
- IDLE: start=1 latches exponent, bit counter=WIDTH-1, goes to CONV_X. busy rises the next cycle.
- Op states CONV_X, CONV_1, SQR, MUL, POST each have two phases:
  - ISSUE: one cycle; mmm_start=1 with selects valid.
  - WAIT: selects held stable until and including the mmm_done cycle.
  - On the mmm_done cycle: the op's write enable pulses for exactly that cycle, and the state advances next cycle.
- Op definitions (A, B -> destination):
  - CONV_X: A=01 message, B=01 R2 -> z_we. Next CONV_1.
  - CONV_1: A=10 one, B=01 R2 -> p_we (Montgomery 1). Next SQR.
  - SQR: A=00 P, B=00 with op_b_reg_sel=0 (P) -> p_we. Next MUL if e[cnt]=1, else NEXT.
  - MUL: A=00 P, B=00 with op_b_reg_sel=1 (Z) -> p_we. Next NEXT.
  - NEXT: one cycle, no strobes. If cnt=0 go to POST; else cnt-1 and go to SQR.
  - POST: A=00 P, B=10 one -> p_we (leave Montgomery domain). Next DONE.
- DONE: done=1 and busy=1 for one cycle, then IDLE. busy=0 in IDLE.
- mmm_start count per run: 2 + WIDTH + popcount(e) + 1.
- start while busy: ignored; latched exponent unchanged.
- mmm_done outside a WAIT phase, or in the same cycle as ISSUE: ignored; no write enable.
- mmm_done and start in the same IDLE cycle: start accepted, mmm_done ignored.
- e=0: all SQR steps run, no MUL; result 1.
- At most one of p_we/z_we/mmm_start/done high in any cycle.

Optional Feature:
- Macro: MODEXP_LZ_SKIP_EN.
- Defined:
  - NEXT-style skip cycles replace SQR for leading zero bits of e (bits above the highest set bit). One cycle per skipped bit, no mmm_start; the counter decrements.
  - The first SQR is issued at the highest set bit.
  - e=0: after CONV_1, skip all bits and go to POST.
  - mmm_start count: 2 + (msb_index+1) + popcount(e) + 1, or 3 for e=0.
- Undefined: all WIDTH bits processed as above.
- Final P value is identical either way.

Test Plan:
- Reset then idle, no start -> all outputs 0 for 20 cycles; mmm_done pulses give no p_we/z_we.
- WIDTH=8, e=0x05, model multiplier with done 4 cycles after start -> 13 mmm_starts, sequence CONV_X,CONV_1,S×5,S,M,S,S,M,POST. z_we once, p_we 12 times, one done pulse, P=x^5 mod N.
- e=0x00 (macro off) -> 11 mmm_starts, no MUL. e=0xFF -> 19 mmm_starts. P matches the reference model in both.
- Macro on, e=0x05 -> 8 mmm_starts (2+3+2+1). e=0x00 -> 3 mmm_starts. Results identical to macro off.
- start pulsed while busy and stray mmm_done during ISSUE -> no state change, no extra write enables, result unchanged.
- rst_n=0 for one cycle during the WAIT of the 3rd SQR -> IDLE next cycle, all outputs 0. The following mmm_done is ignored. A new start then completes correctly.
